// File: rtl/uart_tx_periph_pkg.sv
// uart_tx_periph_pkg: register map, bit positions and FSM encodings (state PARITY only with UART_TX_PARITY_EN)
package uart_tx_periph_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_INT_EN = 1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4} state_t;
`endif
  function automatic logic [15:0] bit_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction
endpackage

// File: rtl/uart_tx_periph_fifo.sv
// uart_tx_fifo: byte FIFO with push/pop, full/empty flags and occupancy count
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  // storage array, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers and count; a pop on a full FIFO frees the slot for a same-edge push
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter with FIFO and interrupt; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        int_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [15:0] divisor, bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg, head;
  logic par, tx_en, int_en, overflow, full, empty, busy, wr, push, start;
  logic [1:0] rsel;
  logic [CW-1:0] count;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16]};
  assign rsel   = addr[3:2];
  assign wr     = ce && we && (sel != 4'd0);
  assign push   = wr && rsel == REG_TXDATA;
  assign busy   = state != S_IDLE;
  assign start  = tx_en && !empty && (state == S_IDLE || (state == S_STOP && bit_cnt == 16'd0));
  assign status = {20'd0, 8'(count), overflow, busy, empty, full};
  assign int_o  = int_en && ((empty && !busy) || overflow);
  assign data_o = !(ce && !we) ? 32'd0 :
                  rsel == REG_STATUS  ? status :
                  rsel == REG_CTRL    ? {30'd0, int_en, tx_en} :
                  rsel == REG_DIVISOR ? {16'd0, divisor} : 32'd0;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (start),
    .din   (data_i[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // control registers and sticky overflow (set has priority over W1C clear)
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_en    <= 1'b0;
      int_en   <= 1'b0;
      divisor  <= 16'(BAUD_DIV);
      overflow <= 1'b0;
    end else begin
      if (wr && rsel == REG_CTRL) begin
        tx_en  <= data_i[CTRL_TX_EN];
        int_en <= data_i[CTRL_INT_EN];
      end
      if (wr && rsel == REG_DIVISOR) divisor <= data_i[15:0];
      if (push && full && !start) overflow <= 1'b1;
      else if (wr && rsel == REG_STATUS && data_i[ST_OVF]) overflow <= 1'b0;
    end
  end
  // transmit FSM: bit timer reloads from the live divisor at every bit boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      txd     <= 1'b1;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      par     <= 1'b0;
    end else if (start) begin
      state   <= S_START;
      txd     <= 1'b0;
      bit_cnt <= bit_reload(divisor);
      bit_idx <= 3'd0;
      shreg   <= head;
      par     <= ^head;
    end else if (state != S_IDLE) begin
      if (bit_cnt != 16'd0) begin
        bit_cnt <= bit_cnt - 16'd1;
      end else begin
        bit_cnt <= bit_reload(divisor);
        case (state)
          S_START: begin
            state <= S_DATA;
            txd   <= shreg[0];
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              txd   <= par;
`else
              state <= S_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state <= S_STOP;
            txd   <= 1'b1;
          end
`endif
          default: begin
            state <= S_IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
